dac_multi: RTL and testbench
============================

Name: dac_multi

Overview:
- Multi-channel successor to the single-channel audio DAC.
- Takes packed unsigned PCM frames over a valid/ready handshake into a one-frame holding buffer, and commits that buffer to the active registers on each rising edge of the sample clock.
- Drives one 1-bit output per channel, each from a first-order sigma-delta (PDM) or a PWM modulator; the mode is selectable at runtime.
- Sits between the audio mixer/CPU sample FIFO and the board output pins / RC filters.

Parameters:
- BITDEPTH, 12, sample width per channel (unsigned, offset-binary).
- CHANNELS, 2, number of independent output channels (1..8).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_clock  in  1  sample-rate square wave, synchronous to clk; a rising edge commits a frame.
- pcm  in  CHANNELS*BITDEPTH  frame; channel k occupies bits [k*BITDEPTH +: BITDEPTH].
- pcm_valid  in  1  frame on pcm is valid.
- pcm_ready  out  1  holding buffer empty; a frame is accepted when pcm_valid and pcm_ready are both high.
- mode  in  1  0 = sigma-delta (PDM), 1 = PWM; sampled only at a commit.
- underrun_clr  in  1  single-cycle pulse that clears underrun.
- underrun  out  1  sticky flag: a commit happened with the holding buffer empty.
- out  out  CHANNELS  modulated outputs, registered.

Behaviour:
- Reset (async assert, sync release):
  - out=0, underrun=0, pcm_ready=1, holding buffer empty.
  - Active PCM=0, active mode=PDM, accumulators=0, PWM counter=0, sample_clock edge register=0.
- Strobe: sample_clock_q is sample_clock registered; strobe = sample_clock & ~sample_clock_q. There is exactly one strobe cycle per rising edge.
- Holding buffer:
  - Accept when pcm_valid & pcm_ready. full is set and pcm_ready drops on the next cycle.
  - No combinational path from pcm_valid to pcm_ready.
- Commit on a strobe cycle:
  - If full: active PCM <= holding buffer, full cleared, pcm_ready=1 on the next cycle.
  - If empty: active PCM keeps its previous value, underrun is set.
  - A write accepted in the strobe cycle itself (buffer was empty) lands in the holding buffer. It is not committed until the next strobe, and underrun is still set.
- Mode: active mode <= mode on every strobe. If the new mode differs from the current one, all accumulators and the PWM counter are cleared in the same edge.
- PDM, per channel:
  - acc is BITDEPTH+1 bits; acc <= {1'b0, acc[BITDEPTH-1:0]} + active_pcm every cycle.
  - out[k] <= carry (bit BITDEPTH) of the sum.
  - Average duty = pcm/2^BITDEPTH. pcm=0 gives constant 0; pcm=2^BITDEPTH-1 gives one low cycle per 2^BITDEPTH.
- PWM:
  - One shared BITDEPTH-bit counter, free-running, wraps from 2^BITDEPTH-1 to 0.
  - out[k] <= (cnt < active_pcm[k]).
  - pcm=0 gives constant 0; pcm=2^BITDEPTH-1 gives one low cycle per period.
- Latency: for a strobe in cycle N, the active registers update at the end of cycle N, and out first reflects the new value in cycle N+2.
- underrun:
  - Set by an underrun commit; cleared by underrun_clr.
  - Set and clear in the same cycle: set wins.
- Reset mid-frame discards the holding buffer and active state immediately; out drops to 0 asynchronously.

Decomposition:
- Shared package dac_pkg:
  - mode constants DAC_MODE_PDM=1'b0, DAC_MODE_PWM=1'b1;
  - a localparam function for the channel slice offset.
- Sub-module dac_chan, one per channel via generate:
  - inputs: clk, rst_n, active_pcm, active mode, shared PWM counter, clear pulse;
  - contains the PDM accumulator and the output register.
- Top level (dac_multi) owns: edge detect, holding buffer and handshake, commit logic, mode latch, PWM counter, underrun flag.

Test Plan:
- Defaults (BITDEPTH=12, CHANNELS=2), PDM mode:
  - Write frame ch0=2048, ch1=0 before the first strobe.
  - After the commit, ch0 toggles every cycle (duty exactly 2048/4096 over any 4096-cycle window); ch1 stays 0.
  - First change on out appears 2 clk after the strobe cycle.
- PWM mode:
  - ch0=1024, ch1=4095.
  - Over each 4096-cycle period after the commit, ch0 is high for exactly 1024 cycles (counter 0..1023) and ch1 for 4095.
- Underrun:
  - No write between two strobes: underrun goes high after the second strobe and out keeps the previous duty.
  - underrun_clr pulsed in the same cycle as a new underrun: underrun stays 1.
- Handshake:
  - Hold pcm_valid high continuously: exactly one frame is accepted per strobe, and pcm_ready is low between commit and the next accept.
  - A frame presented in the strobe cycle is committed at the following strobe.
- Mode switch:
  - Change mode 0 to 1 between strobes: the output is unchanged until the strobe, then the accumulators and counter are 0 and the PWM sequence starts at cnt=0.
- Reset mid-operation:
  - Assert rst_n low while a frame is held and out is toggling: out=0, pcm_ready=1, underrun=0 immediately, without a clk edge.
  - After release, pcm=0 behaviour holds until the first commit.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel PDM/PWM audio DAC.
package dac_pkg;

  localparam logic DAC_MODE_PDM = 1'b0;
  localparam logic DAC_MODE_PWM = 1'b1;

  // Bit offset of channel k inside a packed PCM frame.
  function automatic int chan_offset(input int k, input int bitdepth);
    return k * bitdepth;
  endfunction

endpackage

// File: rtl/dac_chan.sv
// One output channel: first-order sigma-delta accumulator plus PWM compare,
// both feeding a single registered output bit.
module dac_chan
  import dac_pkg::*;
#(
  parameter int BITDEPTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITDEPTH-1:0] active_pcm,
  input  logic                active_mode,
  input  logic [BITDEPTH-1:0] pwm_cnt,
  input  logic                clr,
  output logic                out
);

  logic [BITDEPTH-1:0] acc_reg;
  logic [BITDEPTH:0]   sum;

  // Only the low bits are kept; the carry is the PDM output bit.
  assign sum = {1'b0, acc_reg} + {1'b0, active_pcm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      out     <= 1'b0;
    end else begin
      acc_reg <= clr ? '0 : sum[BITDEPTH-1:0];
      out     <= (active_mode == DAC_MODE_PWM) ? (pwm_cnt < active_pcm) : sum[BITDEPTH];
    end
  end

endmodule

// File: rtl/dac_multi.sv
// Multi-channel audio DAC: valid/ready frame buffer committed on each rising
// sample_clock edge, driving one PDM or PWM modulator per channel.
module dac_multi
  import dac_pkg::*;
#(
  parameter int BITDEPTH = 12,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_clock,
  input  logic [CHANNELS*BITDEPTH-1:0] pcm,
  input  logic                         pcm_valid,
  output logic                         pcm_ready,
  input  logic                         mode,
  input  logic                         underrun_clr,
  output logic                         underrun,
  output logic [CHANNELS-1:0]          out
);

  logic                         sample_clock_q_reg;
  logic                         strobe;
  logic                         accept;
  logic                         clr;
  logic                         full_reg;
  logic                         mode_reg;
  logic                         underrun_reg;
  logic [CHANNELS*BITDEPTH-1:0] hold_reg;
  logic [CHANNELS*BITDEPTH-1:0] active_reg;
  logic [BITDEPTH-1:0]          cnt_reg;

  assign strobe    = sample_clock & ~sample_clock_q_reg;
  assign accept    = pcm_valid & ~full_reg;
  // A mode change restarts every modulator from a known phase.
  assign clr       = strobe & (mode != mode_reg);
  assign pcm_ready = ~full_reg;
  assign underrun  = underrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_clock_q_reg <= 1'b0;
      full_reg           <= 1'b0;
      hold_reg           <= '0;
      active_reg         <= '0;
      mode_reg           <= DAC_MODE_PDM;
      cnt_reg            <= '0;
      underrun_reg       <= 1'b0;
    end else begin
      sample_clock_q_reg <= sample_clock;
      cnt_reg            <= clr ? '0 : cnt_reg + 1'b1;

      if (accept) hold_reg <= pcm;

      // Full buffer never accepts, so commit and accept are exclusive here.
      if (strobe && full_reg) begin
        active_reg <= hold_reg;
        full_reg   <= 1'b0;
      end else if (accept) begin
        full_reg   <= 1'b1;
      end

      if (strobe) mode_reg <= mode;

      if (strobe && !full_reg) underrun_reg <= 1'b1;
      else if (underrun_clr)   underrun_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      localparam int OFS = chan_offset(gi, BITDEPTH);
      dac_chan #(.BITDEPTH(BITDEPTH)) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_pcm  (active_reg[OFS +: BITDEPTH]),
        .active_mode (mode_reg),
        .pwm_cnt     (cnt_reg),
        .clr         (clr),
        .out         (out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_dac_multi.sv
// Self-checking bench for dac_multi: duty-cycle vectors through a scoreboard
// plus hand-written latency, underrun, handshake and reset sequences.
module tb_dac_multi;

  localparam int BD = 12;
  localparam int NCH = 2;
  localparam int WIN = 4096;

  logic            clk;
  logic            rst_n;
  logic            sample_clock;
  logic [NCH*BD-1:0] pcm;
  logic            pcm_valid;
  logic            pcm_ready;
  logic            mode;
  logic            underrun_clr;
  logic            underrun;
  logic [NCH-1:0]  out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic mode;
    int   p0, p1;
    int   e0, e1;
  } vec_t;

  typedef struct {
    int e0, e1;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  dac_multi #(.BITDEPTH(BD), .CHANNELS(NCH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_clock (sample_clock),
    .pcm          (pcm),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .mode         (mode),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .out          (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic write_frame(input int p0, input int p1);
    int n = 0;
    while (!pcm_ready && n < 50) begin
      tick();
      n++;
    end
    if (!pcm_ready) check("write_ready_timeout", 0, 1);
    pcm       = {BD'(p1), BD'(p0)};
    pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
  endtask

  // Raise sample_clock for one cycle; returns in the cycle after the strobe.
  task automatic do_strobe(input logic m);
    mode         = m;
    sample_clock = 1'b1;
    tick();
    sample_clock = 1'b0;
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < WIN; i++) begin
      h0 += int'(out[0]);
      h1 += int'(out[1]);
      tick();
    end
  endtask

  task automatic window_check(input string name);
    int h0, h1;
    exp_t e;
    measure(h0, h1);
    e = sb.pop_front();
    check({name, "_ch0"}, h0, e.e0);
    check({name, "_ch1"}, h1, e.e1);
  endtask

  initial begin
    int n;
    int accepts;
    int h;

    vecs[0] = '{1'b0, 2048,    0, 2048,    0};
    vecs[1] = '{1'b1, 1024, 4095, 1024, 4095};
    vecs[2] = '{1'b0, 4095,    1, 4095,    1};
    vecs[3] = '{1'b1, 4095,    1, 4095,    1};
    vecs[4] = '{1'b1,    0, 2048,    0, 2048};
    vecs[5] = '{1'b0,    0, 4095,    0, 4095};

    rst_n        = 1'b1;
    sample_clock = 1'b0;
    pcm          = '0;
    pcm_valid    = 1'b0;
    mode         = 1'b0;
    underrun_clr = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_out", int'(out), 0);
    check("rst_ready", int'(pcm_ready), 1);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    tick();

    // Latency: commit PWM pcm0=1 from idle; out[0] high only in cycle N+2.
    write_frame(1, 0);
    do_strobe(1'b1);
    check("lat_n1", int'(out), 0);
    tick();
    check("lat_n2", int'(out), 1);
    tick();
    check("lat_n3", int'(out), 0);

    foreach (vecs[i]) begin
      write_frame(vecs[i].p0, vecs[i].p1);
      do_strobe(vecs[i].mode);
      tick();
      sb.push_back('{vecs[i].e0, vecs[i].e1});
      window_check($sformatf("vec%0d", i));
    end
    check("no_underrun", int'(underrun), 0);

    // Underrun: strobe with empty buffer keeps previous duty.
    do_strobe(1'b0);
    tick();
    sb.push_back('{0, 4095});
    window_check("underrun_hold");
    check("underrun_set", int'(underrun), 1);

    mode         = 1'b0;
    sample_clock = 1'b1;
    underrun_clr = 1'b1;
    tick();
    sample_clock = 1'b0;
    underrun_clr = 1'b0;
    check("underrun_set_wins", int'(underrun), 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_clr", int'(underrun), 0);

    // Frame presented in the strobe cycle lands in the buffer only.
    pcm          = {BD'(0), BD'(2048)};
    pcm_valid    = 1'b1;
    sample_clock = 1'b1;
    tick();
    pcm_valid    = 1'b0;
    sample_clock = 1'b0;
    check("strobe_wr_ready", int'(pcm_ready), 0);
    check("strobe_wr_underrun", int'(underrun), 1);
    h = 0;
    for (int i = 0; i < 64; i++) begin
      h += int'(out[0]);
      tick();
    end
    check("strobe_wr_not_committed", h, 0);
    do_strobe(1'b0);
    check("commit_ready", int'(pcm_ready), 1);
    tick();
    sb.push_back('{2048, 0});
    window_check("strobe_wr_commit");

    // Continuous valid: one accept per strobe interval.
    pcm       = {BD'(2048), BD'(2048)};
    pcm_valid = 1'b1;
    accepts   = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      sample_clock = ((cyc % 20) >= 10);
      if (cyc == 5) check("cont_ready_low", int'(pcm_ready), 0);
      if (pcm_ready) accepts++;
      tick();
    end
    pcm_valid    = 1'b0;
    sample_clock = 1'b0;
    check("cont_accepts", accepts, 5);

    // Reset while a frame is held and out is toggling.
    n = 0;
    while (!out[0] && n < 10) begin
      tick();
      n++;
    end
    check("pre_reset_out0_high", int'(out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_ready", int'(pcm_ready), 1);
    check("async_rst_underrun", int'(underrun), 0);
    tick();
    tick();
    rst_n = 1'b1;
    h = 0;
    for (int i = 0; i < 100; i++) begin
      h += int'(out[0]) + int'(out[1]);
      tick();
    end
    check("post_reset_quiet", h, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
